// File: rtl/i2c_master_pkg.sv
// Shared types and constants for the single-byte I2C write master.
// Holds the controller state encoding, the R/W bit value and bus framing counts.
// Optional feature macro used by the top: I2C_MASTER_STOP_ON_NACK_EN.
package i2c_master_pkg;

  // Controller phases, walked in declaration order for a full write.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_ADDR     = 3'd2,
    ST_ADDR_ACK = 3'd3,
    ST_DATA     = 3'd4,
    ST_DATA_ACK = 3'd5,
    ST_STOP     = 3'd6
  } state_t;

  // R/W bit appended to the 7-bit address; this master only writes.
  localparam logic I2C_RW_WRITE = 1'b0;

  // Bus framing counts, in bits and SCL quarter-periods.
  localparam int BYTE_BITS        = 8;
  localparam int QUARTERS_PER_BIT = 4;
  localparam int START_QUARTERS   = 2;
  localparam int STOP_QUARTERS    = 3;

  // Index of the last bit within a byte and the quarter where ACK is sampled.
  localparam logic [2:0] BIT_LAST     = 3'(BYTE_BITS - 1);
  localparam logic [1:0] ACK_SAMPLE_Q = 2'd2;

  // Last quarter index of the phase currently being executed.
  function automatic logic [1:0] last_quarter(input state_t s);
    logic [1:0] q;
    case (s)
      ST_START: q = 2'(START_QUARTERS - 1);
      ST_STOP:  q = 2'(STOP_QUARTERS - 1);
      default:  q = 2'(QUARTERS_PER_BIT - 1);
    endcase
    return q;
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period timebase: one-cycle tick every CLK_DIV clk cycles while running.
// Latency: first tick CLK_DIV cycles after run rises; counter held at zero when idle.
// Backpressure: none; the tick is free-running whenever run is high.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count clk cycles within a quarter; restart from zero whenever idle.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = run && (cnt == CNT_MAX);

endmodule

// File: rtl/i2c_master_wr.sv
// Single-byte I2C write master: START, addr+W, ACK, data, ACK, STOP on open-drain SDA.
// Latency: 77*CLK_DIV cycles from busy rising to done (41*CLK_DIV on early NACK stop).
// Backpressure: start is ignored while busy. Macro I2C_MASTER_STOP_ON_NACK_EN: address NACK jumps to STOP.
module i2c_master_wr
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       scl,
  inout  wire        sda
);

  state_t     state, state_nxt;
  logic [1:0] qcnt, qcnt_nxt;
  logic [2:0] bitcnt, bitcnt_nxt;
  logic [6:0] addr_q;
  logic [7:0] data_q;
  logic       tick;
  logic       accept;
  logic       end_of_txn;
  logic       ack_sample;
  logic       sda_is_low;
  logic       sda_low;
  logic [7:0] tx_byte;
  logic       tx_bit;

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (busy),
    .tick (tick)
  );

  assign busy   = (state != ST_IDLE);
  assign accept = (state == ST_IDLE) && start;

  // State register: phase, quarter within the phase, bit within the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      qcnt   <= '0;
      bitcnt <= '0;
    end else begin
      state  <= state_nxt;
      qcnt   <= qcnt_nxt;
      bitcnt <= bitcnt_nxt;
    end
  end

  // Next-state: advance one quarter per tick, roll bits and phases at phase ends.
  always_comb begin
    state_nxt  = state;
    qcnt_nxt   = qcnt;
    bitcnt_nxt = bitcnt;
    end_of_txn = 1'b0;
    if (state == ST_IDLE) begin
      if (start) begin
        state_nxt  = ST_START;
        qcnt_nxt   = '0;
        bitcnt_nxt = '0;
      end
    end else if (tick) begin
      if (qcnt != last_quarter(state)) begin
        qcnt_nxt = qcnt + 2'd1;
      end else begin
        qcnt_nxt = '0;
        case (state)
          ST_START: state_nxt = ST_ADDR;
          ST_ADDR: begin
            if (bitcnt == BIT_LAST) begin
              bitcnt_nxt = '0;
              state_nxt  = ST_ADDR_ACK;
            end else begin
              bitcnt_nxt = bitcnt + 3'd1;
            end
          end
          ST_ADDR_ACK: begin
`ifdef I2C_MASTER_STOP_ON_NACK_EN
            // ack_error was set at q2 of this bit, so it reflects the address ACK only.
            state_nxt = ack_error ? ST_STOP : ST_DATA;
`else
            state_nxt = ST_DATA;
`endif
          end
          ST_DATA: begin
            if (bitcnt == BIT_LAST) begin
              bitcnt_nxt = '0;
              state_nxt  = ST_DATA_ACK;
            end else begin
              bitcnt_nxt = bitcnt + 3'd1;
            end
          end
          ST_DATA_ACK: state_nxt = ST_STOP;
          ST_STOP: begin
            state_nxt  = ST_IDLE;
            end_of_txn = 1'b1;
          end
          default: state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // Resolve the pin level; anything other than a clean 0 (1, x, z) is a NACK.
  always_comb begin
    case (sda)
      1'b0:    sda_is_low = 1'b1;
      default: sda_is_low = 1'b0;
    endcase
  end

  // Sample the slave ACK on the last cycle of q2 of either ACK bit.
  assign ack_sample = tick && (qcnt == ACK_SAMPLE_Q) &&
                      ((state == ST_ADDR_ACK) || (state == ST_DATA_ACK));

  // Datapath: capture request on accept, track NACK, pulse done at the end of STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      data_q    <= '0;
      ack_error <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= end_of_txn;
      if (accept) begin
        addr_q    <= addr;
        data_q    <= data;
        ack_error <= 1'b0;
      end else if (ack_sample && !sda_is_low) begin
        ack_error <= 1'b1;
      end
    end
  end

  assign tx_byte = (state == ST_ADDR) ? {addr_q, I2C_RW_WRITE} : data_q;
  assign tx_bit  = tx_byte[3'd7 - bitcnt];

  // Output decode: SCL is low in q0/q1 and high in q2/q3 of every bit.
  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    case (state)
      ST_IDLE: begin
        scl     = 1'b1;
        sda_low = 1'b0;
      end
      ST_START: begin
        scl     = 1'b1;
        sda_low = 1'b1;
      end
      ST_ADDR, ST_DATA: begin
        scl     = qcnt[1];
        sda_low = !tx_bit;
      end
      ST_ADDR_ACK, ST_DATA_ACK: begin
        scl     = qcnt[1];
        sda_low = 1'b0;
      end
      ST_STOP: begin
        scl     = (qcnt != 2'd0);
        sda_low = (qcnt != 2'd2);
      end
      default: begin
        scl     = 1'b1;
        sda_low = 1'b0;
      end
    endcase
  end

  // Open-drain pin: only ever pulls low or releases.
  assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_wr.sv
// Scoreboard bench for i2c_master_wr: stimulus queues expected transactions,
// a bus monitor (with a simple ACKing slave) decodes SCL/SDA and checks on done.
// Honours I2C_MASTER_STOP_ON_NACK_EN for the expected early-stop length.
module tb_i2c_master_wr;

  localparam int CLK_DIV     = 5;
  localparam int FULL_CYC    = 77 * CLK_DIV;
  localparam int SHORT_CYC   = 41 * CLK_DIV;
  localparam int FULL_RISES  = 19;
  localparam int SHORT_RISES = 10;
`ifdef I2C_MASTER_STOP_ON_NACK_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] data = '0;
  logic       busy, done, ack_error, scl;
  wire        sda;
  logic       slave_low = 1'b0;
  logic       ack_addr = 1'b0;
  logic       ack_data = 1'b0;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_master_wr #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .addr      (addr),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .ack_error (ack_error),
    .scl       (scl),
    .sda       (sda)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr_byte;
    logic [7:0] data_byte;
    logic       full;
    int         cycles;
    int         rises;
    logic       ack_err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, expv, expv);
  endtask

  // Bus monitor + slave: decode bits on SCL rises, ACK on chosen bits, score on done.
  logic       prev_busy = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1;
  int         cyc = 0, rises = 0, falls = 0;
  logic [7:0] cap_a = '0, cap_d = '0;
  logic       stop_seen = 1'b0;
  exp_t       e;

  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      cyc = 0; rises = 0; falls = 0;
      cap_a = '0; cap_d = '0; stop_seen = 1'b0;
    end
    if (busy) begin
      cyc++;
      if (!prev_scl && scl) begin
        rises++;
        if (rises <= 8) cap_a[8 - rises] = sda;
        else if (rises >= 10 && rises <= 17) cap_d[17 - rises] = sda;
      end
      if (prev_scl && scl && !prev_sda && sda === 1'b1) stop_seen = 1'b1;
      if (prev_scl && !scl) begin
        falls++;
        if (falls == 9) slave_low = ack_addr;
        else if (falls == 18) slave_low = ack_data;
        else slave_low = 1'b0;
      end
    end
    if (rst) slave_low = 1'b0;
    if (done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("txn_cycles", cyc, e.cycles);
        chk("txn_ack_error", ack_error, e.ack_err);
        chk("txn_scl_rises", rises, e.rises);
        chk("txn_addr_bits", cap_a, e.addr_byte);
        if (e.full) chk("txn_data_bits", cap_d, e.data_byte);
        chk("txn_stop_seen", stop_seen, 1);
        chk("txn_busy_low_at_done", busy, 0);
      end
    end
    prev_busy = busy;
    prev_scl  = scl;
    prev_sda  = sda;
  end

  // Issue one transaction; optionally queue the expected outcome.
  task automatic launch(input logic [6:0] a, input logic [7:0] d,
                        input logic aa, input logic ad, input logic expect_done);
    exp_t n;
    logic short_txn;
    short_txn   = STOP_EN && !aa;
    n.addr_byte = {a, 1'b0};
    n.data_byte = d;
    n.full      = !short_txn;
    n.cycles    = short_txn ? SHORT_CYC : FULL_CYC;
    n.rises     = short_txn ? SHORT_RISES : FULL_RISES;
    n.ack_err   = !(aa && (ad || short_txn));
    if (expect_done) exp_q.push_back(n);
    @(negedge clk);
    addr = a; data = d; ack_addr = aa; ack_data = ad; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("ack_error_cleared_on_accept", ack_error, 0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk({name, "_timeout"}, 0, 1);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_error", ack_error, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal write, both bytes ACKed.
    launch(7'h42, 8'hA5, 1'b1, 1'b1, 1'b1);
    wait_done("t1");

    // No slave at all: NACK stays sticky until next accept.
    launch(7'h1B, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_done("t2");
    repeat (50) @(negedge clk);
    chk("ack_error_sticky", ack_error, 1);

    // Address ACKed, data NACKed: full length, proper STOP.
    launch(7'h7F, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_done("t3");

    // Address NACKed: early STOP only when the option is built in.
    launch(7'h00, 8'hFF, 1'b0, 1'b0, 1'b1);
    wait_done("t4");

    // start and data changes while busy must be ignored.
    launch(7'h55, 8'h96, 1'b1, 1'b1, 1'b1);
    repeat (100) @(negedge clk);
    addr = 7'h11; data = 8'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_ignored", busy, 1);
    wait_done("t5");
    repeat (5) @(negedge clk);
    chk("single_done_t5", done_seen, 5);

    // Reset in the middle of the data byte: bus released, no done.
    launch(7'h3C, 8'hC3, 1'b1, 1'b1, 1'b0);
    repeat (220) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_scl", scl, 1);
    chk("midrst_sda", sda, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Normal transaction after the abort.
    launch(7'h2C, 8'h5A, 1'b1, 1'b1, 1'b1);
    wait_done("t7");
    repeat (5) @(negedge clk);
    chk("done_total", done_seen, 6);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
